// File: rtl/cla_pkg.sv
// Shared definitions for the multi-word CLA add/subtract sequencer.
//   CLA_WORD_W  : width of one adder slice
//   seq_state_t : sequencer FSM state encoding
package cla_pkg;

    localparam int CLA_WORD_W = 8;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_DONE
    } seq_state_t;

endpackage

// File: rtl/CLA_8bit.sv
// 8-bit carry-lookahead adder slice.
//   a, b : slice operands
//   cin  : carry into bit 0
//   sum  : slice sum (modulo 2^8)
//   cout : carry out of bit 7
module CLA_8bit
    import cla_pkg::*;
(
    input  logic [CLA_WORD_W-1:0] a,
    input  logic [CLA_WORD_W-1:0] b,
    input  logic                  cin,
    output logic [CLA_WORD_W-1:0] sum,
    output logic                  cout
);

    logic [CLA_WORD_W-1:0] p;
    logic [CLA_WORD_W-1:0] g;
    logic [CLA_WORD_W:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is built directly from generate/propagate terms and cin
    // (c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin), never from c[i].
    always_comb begin
        logic acc;
        logic run;
        c    = '0;
        c[0] = cin;
        acc  = 1'b0;
        run  = 1'b0;
        for (int unsigned i = 0; i < CLA_WORD_W; i++) begin
            acc = g[i];
            run = p[i];
            for (int unsigned k = 1; k <= i; k++) begin
                acc = acc | (run & g[i-k]);
                run = run & p[i-k];
            end
            c[i+1] = acc | (run & cin);
        end
    end

    assign sum  = p ^ c[CLA_WORD_W-1:0];
    assign cout = c[CLA_WORD_W];

endmodule

// File: rtl/cla_multiword_add_seq.sv
// Multi-word add/subtract sequencer: runs NUM_WORDS 8-bit slices, LSB first,
// through one shared CLA_8bit with a registered carry between slices.
//   clk, rst_n                 : clock, async active-low reset
//   start_valid / start_ready  : operand handshake (a_in, b_in, carry_in, op_sub)
//   result_valid / result_ready: result handshake (sum_out, carry_out, overflow)
//   op_sub = 1 computes a_in - b_in as a_in + ~b_in + 1 (carry_in ignored)
//   carry_out = bit OPW of the result; overflow = signed two's-complement overflow
module cla_multiword_add_seq
    import cla_pkg::*;
#(
    parameter int NUM_WORDS = 4
)
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_valid,
    output logic                            start_ready,
    input  logic [NUM_WORDS*CLA_WORD_W-1:0] a_in,
    input  logic [NUM_WORDS*CLA_WORD_W-1:0] b_in,
    input  logic                            carry_in,
    input  logic                            op_sub,
    output logic                            result_valid,
    input  logic                            result_ready,
    output logic [NUM_WORDS*CLA_WORD_W-1:0] sum_out,
    output logic                            carry_out,
    output logic                            overflow
);

    localparam int OPW   = NUM_WORDS * CLA_WORD_W;
    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    seq_state_t state;
    seq_state_t state_nxt;

    logic [OPW-1:0]        a_reg;
    logic [OPW-1:0]        b_reg;
    logic                  carry_reg;
    logic [IDX_W-1:0]      idx;
    logic [CLA_WORD_W-1:0] slice_a;
    logic [CLA_WORD_W-1:0] slice_b;
    logic [CLA_WORD_W-1:0] slice_sum;
    logic                  slice_cout;
    logic                  last_slice;

    assign slice_a    = a_reg[CLA_WORD_W*idx +: CLA_WORD_W];
    assign slice_b    = b_reg[CLA_WORD_W*idx +: CLA_WORD_W];
    assign last_slice = (idx == LAST_IDX);

    CLA_8bit u_cla (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_nxt    = state;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        case (state)
            SEQ_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_nxt = SEQ_RUN;
            end
            SEQ_RUN: begin
                if (last_slice) state_nxt = SEQ_DONE;
            end
            SEQ_DONE: begin
                result_valid = 1'b1;
                if (result_ready) state_nxt = SEQ_IDLE;
            end
            default: state_nxt = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEQ_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                SEQ_IDLE: begin
                    if (start_valid) begin
                        a_reg     <= a_in;
                        b_reg     <= op_sub ? ~b_in : b_in;
                        carry_reg <= op_sub | carry_in;
                        idx       <= '0;
                    end
                end
                SEQ_RUN: begin
                    sum_out[CLA_WORD_W*idx +: CLA_WORD_W] <= slice_sum;
                    carry_reg <= slice_cout;
                    if (last_slice) begin
                        carry_out <= slice_cout;
                        // slice_sum MSB is the result sign being written this edge
                        overflow  <= (a_reg[OPW-1] == b_reg[OPW-1]) &&
                                     (slice_sum[CLA_WORD_W-1] != a_reg[OPW-1]);
                        idx       <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_multiword_add_seq.sv
// Self-checking bench for cla_multiword_add_seq (NUM_WORDS = 4).
module tb_cla_multiword_add_seq;

    localparam int NW  = 4;
    localparam int OPW = 32;

    typedef struct packed {
        logic [OPW-1:0] sum;
        logic           cout;
        logic           ovf;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_valid = 1'b0;
    logic           start_ready;
    logic [OPW-1:0] a_in = '0;
    logic [OPW-1:0] b_in = '0;
    logic           carry_in = 1'b0;
    logic           op_sub = 1'b0;
    logic           result_valid;
    logic           result_ready = 1'b0;
    logic [OPW-1:0] sum_out;
    logic           carry_out;
    logic           overflow;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    cla_multiword_add_seq #(.NUM_WORDS(NW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .carry_in     (carry_in),
        .op_sub       (op_sub),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .sum_out      (sum_out),
        .carry_out    (carry_out),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                   input logic cin, input logic sub);
        logic [OPW-1:0] be;
        logic [OPW:0]   full;
        exp_t           e;
        be    = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, be} + {{OPW{1'b0}}, (sub | cin)};
        e.sum  = full[OPW-1:0];
        e.cout = full[OPW];
        e.ovf  = (a[OPW-1] == be[OPW-1]) && (full[OPW-1] != a[OPW-1]);
        return e;
    endfunction

    task automatic start_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                            input logic cin, input logic sub, input exp_t e);
        int n;
        @(negedge clk);
        a_in = a; b_in = b; carry_in = cin; op_sub = sub; start_valid = 1'b1;
        n = 0;
        while (!start_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", start_ready, 1);
        @(posedge clk);
        #1;
        acc_cyc     = cyc;
        start_valid = 1'b0;
        // scramble inputs: the sequencer must work from its captured copy
        a_in = $urandom; b_in = $urandom; carry_in = ~cin; op_sub = ~sub;
        sb.push_back(e);
    endtask

    task automatic wait_result(input string tag, input bit handshake);
        int   n;
        exp_t e;
        n = 0;
        while (!result_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, result_valid, 1);
        check({tag, "_latency"}, cyc - acc_cyc, NW);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_sum"}, sum_out, e.sum);
            check({tag, "_cout"}, carry_out, e.cout);
            check({tag, "_ovf"}, overflow, e.ovf);
        end else begin
            check({tag, "_sb_empty"}, 0, 1);
        end
        if (handshake) begin
            result_ready = 1'b1;
            @(posedge clk);
            #1;
            result_ready = 1'b0;
        end
    endtask

    initial begin
        logic [OPW-1:0] ra;
        logic [OPW-1:0] rb;
        logic           rc;
        exp_t           e;
        int             n;
        int             prev;
        bit             stable;
        bit             leaked;

        // reset state
        #2;
        check("rst_start_ready", start_ready, 1);
        check("rst_result_valid", result_valid, 0);
        check("rst_sum", sum_out, 0);
        check("rst_cout", carry_out, 0);
        check("rst_ovf", overflow, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0});
        wait_result("add_chain", 1);

        start_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0 | 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0});
        wait_result("sub_borrow", 1);

        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1});
        wait_result("add_ovf", 1);

        // carry_in case, then backpressure in DONE
        start_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, '{32'h2345_678A, 1'b0, 1'b0});
        wait_result("add_cin", 0);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) begin
                a_in = 32'hDEAD_BEEF; b_in = 32'h0BAD_F00D; start_valid = 1'b1;
            end else begin
                start_valid = 1'b0;
            end
            if (sum_out !== 32'h2345_678A || carry_out !== 1'b0 || overflow !== 1'b0 ||
                result_valid !== 1'b1 || start_ready !== 1'b0)
                stable = 1'b0;
        end
        start_valid = 1'b0;
        check("bp_stable", stable, 1);
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        check("bp_released_valid", result_valid, 0);
        check("bp_released_ready", start_ready, 1);
        check("bp_sum_kept", sum_out, 32'h2345_678A);
        leaked = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (result_valid !== 1'b0 || start_ready !== 1'b1) leaked = 1'b1;
        end
        check("bp_no_capture", leaked, 0);

        start_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1});
        wait_result("sub_ovf", 1);

        // reset while idx == 2
        start_op(32'hAAAA_AAAA, 32'h1111_1111, 1'b0, 1'b0, '{32'hBBBB_BBBB, 1'b0, 1'b0});
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_sum", sum_out, 0);
        check("mid_rst_cout", carry_out, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_valid", result_valid, 0);
        check("mid_rst_ready", start_ready, 1);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", start_ready, 1);
        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0100, 1'b0, 1'b0});
        wait_result("post_rst_add", 1);

        // back-to-back with start_valid and result_ready held high
        result_ready = 1'b1;
        @(negedge clk);
        a_in = $urandom; b_in = $urandom; carry_in = 1'($urandom_range(0, 1)); op_sub = 1'b0;
        start_valid = 1'b1;
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!start_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            ra = a_in; rb = b_in; rc = carry_in;
            e = model(ra, rb, rc, 1'b0);
            @(posedge clk);
            #1;
            if (i > 0) check("b2b_interval", cyc - prev, NW + 2);
            prev    = cyc;
            acc_cyc = cyc;
            sb.push_back(e);
            a_in = $urandom; b_in = $urandom; carry_in = 1'($urandom_range(0, 1));
            wait_result("b2b", 0);
            if (i == 2) start_valid = 1'b0;
        end
        @(negedge clk);
        result_ready = 1'b0;
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
